// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC sequencing, start-up wait, RAW stall, branch flush and EX bypass select
module pipe_hazard_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              RST_WAIT = 1,
  parameter int              FWD_EN   = 1,
  parameter int              BR_STAGE = 3,
  parameter int              CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_addr_id_i,
  input  logic [4:0]       rs2_addr_id_i,
  input  logic             rs1_used_id_i,
  input  logic             rs2_used_id_i,
  input  logic [4:0]       rs1_addr_ex_i,
  input  logic [4:0]       rs2_addr_ex_i,
  input  logic [4:0]       rd_addr_ex_i,
  input  logic             rd_wren_ex_i,
  input  logic             is_load_ex_i,
  input  logic [4:0]       rd_addr_mem_i,
  input  logic             rd_wren_mem_i,
  input  logic [4:0]       rd_addr_wb_i,
  input  logic             rd_wren_wb_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_four_o,
  output logic             en_if_id_o,
  output logic             en_id_ex_o,
  output logic             en_ex_mem_o,
  output logic             en_mem_wb_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_ex_mem_o,
  output logic             flush_mem_wb_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = $clog2(RST_WAIT + 1);
  typedef enum logic {S_WAIT, S_RUN} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic run, br, stall, raw, hit1_ex, hit2_ex, hit1_mw, hit2_mw;
  logic [XLEN-1:0] pc_nx;
  function automatic logic hit(input logic [4:0] a, input logic [4:0] d, input logic w);
    return w && d != 5'd0 && a == d;
  endfunction
  function automatic logic [1:0] fwd_sel(input logic [4:0] a, input logic [4:0] dm, input logic wm,
                                         input logic [4:0] dw, input logic ww);
    return hit(a, dm, wm) ? 2'd1 : hit(a, dw, ww) ? 2'd2 : 2'd0;
  endfunction
  always_comb begin
    run      = state == S_RUN;
    hit1_ex  = rs1_used_id_i && hit(rs1_addr_id_i, rd_addr_ex_i, rd_wren_ex_i);
    hit2_ex  = rs2_used_id_i && hit(rs2_addr_id_i, rd_addr_ex_i, rd_wren_ex_i);
    hit1_mw  = rs1_used_id_i && (hit(rs1_addr_id_i, rd_addr_mem_i, rd_wren_mem_i) ||
                                 hit(rs1_addr_id_i, rd_addr_wb_i, rd_wren_wb_i));
    hit2_mw  = rs2_used_id_i && (hit(rs2_addr_id_i, rd_addr_mem_i, rd_wren_mem_i) ||
                                 hit(rs2_addr_id_i, rd_addr_wb_i, rd_wren_wb_i));
    raw      = (FWD_EN != 0) ? is_load_ex_i && (hit1_ex || hit2_ex)
                             : hit1_ex || hit2_ex || hit1_mw || hit2_mw;
    br       = run && br_taken_i;
    // a taken branch squashes the stalled instruction, so it never stalls as well
    stall    = run && raw && !br_taken_i;
    state_nx = (state == S_WAIT && wait_cnt == WW'(1)) ? S_RUN : state;
    pc_nx    = br ? br_target_i : (stall || !run) ? pc_o : pc_o + XLEN'(4);
  end
  assign pc_four_o      = pc_o + XLEN'(4);
  assign en_if_id_o     = !stall;
  assign en_id_ex_o     = 1'b1;
  assign en_ex_mem_o    = 1'b1;
  assign en_mem_wb_o    = 1'b1;
  assign flush_if_id_o  = !run || br;
  assign flush_id_ex_o  = !run || br || stall;
  assign flush_ex_mem_o = !run || (br && BR_STAGE == 3);
  assign flush_mem_wb_o = !run;
  assign fwd_a_o = (FWD_EN != 0 && run) ? fwd_sel(rs1_addr_ex_i, rd_addr_mem_i, rd_wren_mem_i,
                                                  rd_addr_wb_i, rd_wren_wb_i) : 2'd0;
  assign fwd_b_o = (FWD_EN != 0 && run) ? fwd_sel(rs2_addr_ex_i, rd_addr_mem_i, rd_wren_mem_i,
                                                  rd_addr_wb_i, rd_wren_wb_i) : 2'd0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_WAIT;
      wait_cnt    <= WW'(RST_WAIT);
      pc_o        <= RESET_PC;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_nx;
      pc_o  <= pc_nx;
      if (!run) wait_cnt <= wait_cnt - WW'(1);
      if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (br && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It merges PC sequencing, post-reset start-up, data-hazard stall, control-hazard flush and operand-forwarding select into one block. Mode is selected by parameter: forwarding off (stall on every RAW) or forwarding on (stall only on load-use). It drives the enable/flush inputs of the four pipeline registers, the EX operand bypass muxes, and two performance counters.

Parameters:
XLEN, 32, PC and target width
RESET_PC, 32'h0, PC value loaded on reset
RST_WAIT, 1, cycles spent in WAIT after reset release before PC advances (>=1)
FWD_EN, 1, 0 = no forwarding, stall on any RAW; 1 = EX bypass, stall only on load-use
BR_STAGE, 3, stage resolving branches: 2 = EX, 3 = MEM
CNT_W, 16, performance counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
rs1_addr_id_i / rs2_addr_id_i  in  5  ID source registers
rs1_used_id_i / rs2_used_id_i  in  1  ID instruction reads rs1/rs2
rs1_addr_ex_i / rs2_addr_ex_i  in  5  EX source registers (forwarding)
rd_addr_ex_i, rd_wren_ex_i, is_load_ex_i  in  5,1,1  EX destination info
rd_addr_mem_i, rd_wren_mem_i  in  5,1  MEM destination info
rd_addr_wb_i, rd_wren_wb_i  in  5,1  WB destination info
br_taken_i  in  1  taken branch/jump at stage BR_STAGE
br_target_i  in  XLEN  redirect target
pc_o, pc_four_o  out  XLEN  fetch PC, PC+4
en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o  out  1  pipe register enables
flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out  1  synchronous bubble insert (dominates enable)
fwd_a_o, fwd_b_o  out  2  EX operand source: 0 regfile, 1 EX/MEM alu_data, 2 MEM/WB rd_data, 3 unused
stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

Behaviour:
- Reset state (async, immediate, also mid-operation): pc_o=RESET_PC, state=WAIT, wait counter=RST_WAIT, counters=0, all flush outputs=1, all enables=1, fwd=0.
- FSM WAIT: PC held; all four flushes=1; counter decrements each cycle; at counter==1 the next state is RUN. The first fetch of RESET_PC enters IF/ID on the first RUN edge.
- FSM RUN: the priority branch > stall > advance applies.
- Match(a,d) = wren_d && d!=0 && a==d; the source counts only when its used_i=1. x0 is never a hazard.
- FWD_EN=0: stall = a used ID source matches EX, MEM or WB.
- FWD_EN=1: stall = is_load_ex_i && Match(rs1/rs2_id, rd_ex).
- Stall: pc_o held, en_if_id_o=0, flush_id_ex_o=1, EX/MEM and MEM/WB advance. The stall persists every cycle the condition holds.
- Branch (br_taken_i=1): pc_o<=br_target_i next edge, and flush_if_id_o=flush_id_ex_o=1.
  - BR_STAGE=3: flush_ex_mem_o=1 also.
  - Any simultaneous stall is suppressed (the stalled instruction is squashed).
- Advance: pc_o<=pc_o+4, modulo 2^XLEN (0xFFFFFFFC -> 0). pc_four_o=pc_o+4 combinational.
- flush_mem_wb_o=1 only in WAIT.
- Forwarding (FWD_EN=1), evaluated combinationally per operand: fwd=1 if Match(rs_ex, rd_mem); else 2 if Match(rs_ex, rd_wb); else 0. MEM has priority over WB. With FWD_EN=0, fwd is always 0.
- stall_cnt_o: +1 per RUN cycle with an applied stall.
- flush_cnt_o: +1 per RUN cycle with br_taken_i.
- Both counters saturate at all-ones and do not count in WAIT.
- br_target_i misalignment is not checked; it is passed through unchanged.

Test Plan:
- Reset release, RST_WAIT=1: pc_o stays 0 during WAIT with all flush=1, then 0,4,8,12 on successive edges with flushes=0.
- FWD_EN=1: lw x5 in EX, add x6,x5,x1 in ID -> exactly 1 stall cycle (pc held, flush_id_ex=1, stall_cnt=1). Next cycle fwd_a_o=2 for x5.
- FWD_EN=0: add x5 in EX, use x5 in ID -> 3 consecutive stall cycles until x5 leaves WB; stall_cnt=3.
- FWD_EN=1: back-to-back add x5 then sub x7,x5,x5 -> fwd_a_o=fwd_b_o=1, no stall. With rd=x0 writers -> fwd=0.
- BR_STAGE=3: br_taken_i=1, br_target_i=0x40 coincident with a load-use stall -> pc_o=0x40 next edge; flush_if_id/id_ex/ex_mem=1; stall_cnt unchanged; flush_cnt=1.
- PC at 0xFFFFFFFC advancing -> 0x0. Assert rst_ni low mid-stall -> pc_o=RESET_PC immediately and counters=0.
